// File: rtl/conv1_sched.sv
// Conv layer-1 sequencer: steps one shared MAC over every output element and its
// kernel taps, drains the MAC pipeline and hands each result to write-back.
module conv1_sched #(
  parameter int IN_W    = 227,
  parameter int IN_C    = 3,
  parameter int K       = 11,
  parameter int STRIDE  = 4,
  parameter int OUT_HW  = 55,
  parameter int OUT_C   = 96,
  parameter int MAC_LAT = 3,
  parameter int IA_W    = 18,
  parameter int WA_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mem_stall,
  output logic [IA_W-1:0] in_addr,
  output logic [WA_W-1:0] wt_addr,
  output logic            rd_en,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            mac_last,
  output logic            wr_req,
  input  logic            wr_ack,
  output logic [5:0]      out_row,
  output logic [5:0]      out_col,
  output logic [6:0]      out_ch,
  output logic            busy,
  output logic            done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [7:0]      CI_MAX    = 8'(IN_C - 1);
  localparam logic [7:0]      K_MAX     = 8'(K - 1);
  localparam logic [5:0]      HW_MAX    = 6'(OUT_HW - 1);
  localparam logic [6:0]      OC_MAX    = 7'(OUT_C - 1);
  localparam logic [DW-1:0]   DRAIN_MAX = DW'(MAC_LAT - 1);

  // Stride constants let every address term advance by addition alone.
  localparam logic [IA_W-1:0] KX_STEP  = IA_W'(IN_C);
  localparam logic [IA_W-1:0] KY_STEP  = IA_W'(IN_W * IN_C);
  localparam logic [IA_W-1:0] COL_STEP = IA_W'(STRIDE * IN_C);
  localparam logic [IA_W-1:0] ROW_STEP = IA_W'(STRIDE * IN_W * IN_C);
  localparam logic [WA_W-1:0] OC_STEP  = WA_W'(K * K * IN_C);

  logic [2:0]      state;
  logic [7:0]      ci, kx, ky;
  logic [IA_W-1:0] kx_off, ky_off, col_base, row_base;
  logic [WA_W-1:0] wt_tap, oc_base;
  logic [5:0]      oy, ox;
  logic [6:0]      oc;
  logic [DW-1:0]   drain_cnt;
  logic            issue, tap_first, tap_last, elem_last, xfer;

  assign issue     = (state == S_LOAD) && !mem_stall;
  assign tap_first = (ci == 8'd0) && (kx == 8'd0) && (ky == 8'd0);
  assign tap_last  = (ci == CI_MAX) && (kx == K_MAX) && (ky == K_MAX);
  assign elem_last = (oy == HW_MAX) && (ox == HW_MAX) && (oc == OC_MAX);
  assign xfer      = (state == S_WRITE) && wr_ack;

  assign rd_en    = issue;
  assign mac_en   = issue;
  assign mac_clr  = issue && tap_first;
  assign mac_last = issue && tap_last;
  assign wr_req   = (state == S_WRITE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign out_row  = oy;
  assign out_col  = ox;
  assign out_ch   = oc;

  assign in_addr = (state == S_LOAD) ?
                   (row_base + col_base + ky_off + kx_off + IA_W'(ci)) : '0;
  assign wt_addr = (state == S_LOAD) ? (oc_base + wt_tap) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_LOAD;
        S_LOAD:  if (issue && tap_last) state <= S_DRAIN;
        S_DRAIN: if (drain_cnt == DRAIN_MAX) state <= S_WRITE;
        S_WRITE: if (wr_ack) state <= elem_last ? S_DONE : S_LOAD;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tap counters wrap back to zero on the last tap, so each element starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ci     <= '0;
      kx     <= '0;
      ky     <= '0;
      kx_off <= '0;
      ky_off <= '0;
      wt_tap <= '0;
    end else if (issue) begin
      wt_tap <= tap_last ? '0 : wt_tap + WA_W'(1);
      if (ci == CI_MAX) begin
        ci <= '0;
        if (kx == K_MAX) begin
          kx     <= '0;
          kx_off <= '0;
          if (ky == K_MAX) begin
            ky     <= '0;
            ky_off <= '0;
          end else begin
            ky     <= ky + 8'd1;
            ky_off <= ky_off + KY_STEP;
          end
        end else begin
          kx     <= kx + 8'd1;
          kx_off <= kx_off + KX_STEP;
        end
      end else begin
        ci <= ci + 8'd1;
      end
    end
  end

  // Output element indices advance only when write-back accepts the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc       <= '0;
      ox       <= '0;
      oy       <= '0;
      oc_base  <= '0;
      col_base <= '0;
      row_base <= '0;
    end else if (xfer) begin
      if (oc == OC_MAX) begin
        oc      <= '0;
        oc_base <= '0;
        if (ox == HW_MAX) begin
          ox       <= '0;
          col_base <= '0;
          if (oy == HW_MAX) begin
            oy       <= '0;
            row_base <= '0;
          end else begin
            oy       <= oy + 6'd1;
            row_base <= row_base + ROW_STEP;
          end
        end else begin
          ox       <= ox + 6'd1;
          col_base <= col_base + COL_STEP;
        end
      end else begin
        oc      <= oc + 7'd1;
        oc_base <= oc_base + OC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (state == S_DRAIN) begin
      drain_cnt <= (drain_cnt == DRAIN_MAX) ? '0 : drain_cnt + DW'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched: default-size instance walked with random stalls/acks, and a
// reduced instance run over its whole layer, both checked against index arithmetic.
module tb_conv1_sched;

  localparam int IN_W_A = 227, IN_C_A = 3, K_A = 11, S_A = 4, OHW_A = 55, OC_A = 96, LAT_A = 3;
  localparam int TAPS_A = K_A * K_A * IN_C_A;
  localparam int IN_W_B = 3, IN_C_B = 1, K_B = 2, S_B = 1, OHW_B = 2, OC_B = 2, LAT_B = 1;
  localparam int TAPS_B = K_B * K_B * IN_C_B;
  localparam int N_B = OHW_B * OHW_B * OC_B;
  localparam int DONE_AT_B = N_B * (TAPS_B + LAT_B + 1);

  logic clk, rst;
  logic start_a, stall_a, ack_a, start_b, stall_b, ack_b;
  logic [17:0] in_addr_a, in_addr_b;
  logic [15:0] wt_addr_a, wt_addr_b;
  logic rd_en_a, mac_clr_a, mac_en_a, mac_last_a, wr_req_a, busy_a, done_a;
  logic rd_en_b, mac_clr_b, mac_en_b, mac_last_b, wr_req_b, busy_b, done_b;
  logic [5:0] out_row_a, out_col_a, out_row_b, out_col_b;
  logic [6:0] out_ch_a, out_ch_b;

  int vectors = 0;
  int miscompares = 0;

  conv1_sched dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_stall(stall_a),
    .in_addr(in_addr_a), .wt_addr(wt_addr_a), .rd_en(rd_en_a), .mac_clr(mac_clr_a),
    .mac_en(mac_en_a), .mac_last(mac_last_a), .wr_req(wr_req_a), .wr_ack(ack_a),
    .out_row(out_row_a), .out_col(out_col_a), .out_ch(out_ch_a), .busy(busy_a), .done(done_a)
  );

  conv1_sched #(
    .IN_W(IN_W_B), .IN_C(IN_C_B), .K(K_B), .STRIDE(S_B), .OUT_HW(OHW_B),
    .OUT_C(OC_B), .MAC_LAT(LAT_B), .IA_W(18), .WA_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_stall(stall_b),
    .in_addr(in_addr_b), .wt_addr(wt_addr_b), .rd_en(rd_en_b), .mac_clr(mac_clr_b),
    .mac_en(mac_en_b), .mac_last(mac_last_b), .wr_req(wr_req_b), .wr_ack(ack_b),
    .out_row(out_row_b), .out_col(out_col_b), .out_ch(out_ch_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: element e enumerates oc fastest, then ox, then oy; tap t enumerates ci, kx, ky.
  function automatic int exp_in(int iw, int ic, int k, int s, int ohw, int onc, int e, int t);
    int oy, ox, ci, kx, ky;
    ox = (e / onc) % ohw;
    oy = e / (onc * ohw);
    ci = t % ic;
    kx = (t / ic) % k;
    ky = t / (ic * k);
    return ((oy * s + ky) * iw + ox * s + kx) * ic + ci;
  endfunction

  function automatic int exp_wt(int ic, int k, int onc, int e, int t);
    int oc, ci, kx, ky;
    oc = e % onc;
    ci = t % ic;
    kx = (t / ic) % k;
    ky = t / (ic * k);
    return ((oc * k + ky) * k + kx) * ic + ci;
  endfunction

  function automatic logic [18:0] exp_coord(int ohw, int onc, int e);
    int oy, ox, oc;
    oc = e % onc;
    ox = (e / onc) % ohw;
    oy = e / (onc * ohw);
    return {6'(oy), 6'(ox), 7'(oc)};
  endfunction

  task automatic test_reset();
    logic [59:0] snap;
    @(negedge clk);
    #1;
    snap = {in_addr_a, wt_addr_a, rd_en_a, mac_clr_a, mac_en_a, mac_last_a, wr_req_a,
            out_row_a, out_col_a, out_ch_a, busy_a, done_a};
    vectors++;
    if (snap !== 60'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_a: got %h expected 0", snap);
    end
    snap = {in_addr_b, wt_addr_b, rd_en_b, mac_clr_b, mac_en_b, mac_last_b, wr_req_b,
            out_row_b, out_col_b, out_ch_b, busy_b, done_b};
    vectors++;
    if (snap !== 60'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_b: got %h expected 0", snap);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_layer_walk(input int n_elem);
    int t, s0, d;
    bit stall, forced;
    logic [17:0] ei;
    logic [15:0] ew;
    logic [18:0] ec, got_c;
    logic [3:0] exp_s, got_s;
    @(negedge clk);
    start_a = 1; stall_a = 0; ack_a = 0;
    s0 = 0;
    for (int e = 0; e < n_elem; e++) begin
      ec = exp_coord(OHW_A, OC_A, e);
      t = 0;
      forced = 0;
      while (t < TAPS_A) begin
        @(negedge clk);
        if (e == 0) stall = (t == 100) && (s0 < 5);
        else if (e == 2) stall = (t == 0) && !forced;
        else if (e == 3) stall = (t == TAPS_A - 1) && !forced;
        else stall = ($urandom_range(15) == 0);
        if (stall && e == 0) s0++;
        if (stall) forced = 1;
        stall_a = stall;
        ack_a = 1'($urandom_range(1));
        start_a = 1'($urandom_range(1));
        #1;
        ei = 18'(exp_in(IN_W_A, IN_C_A, K_A, S_A, OHW_A, OC_A, e, t));
        ew = 16'(exp_wt(IN_C_A, K_A, OC_A, e, t));
        exp_s = {!stall, !stall, !stall && (t == 0), !stall && (t == TAPS_A - 1)};
        got_s = {rd_en_a, mac_en_a, mac_clr_a, mac_last_a};
        got_c = {out_row_a, out_col_a, out_ch_a};
        vectors++;
        if (got_s !== exp_s) begin
          miscompares++;
          $display("[TB] FAIL load_strobes e=%0d t=%0d: got %b expected %b", e, t, got_s, exp_s);
        end
        vectors++;
        if (in_addr_a !== ei) begin
          miscompares++;
          $display("[TB] FAIL in_addr e=%0d t=%0d: got %0d expected %0d", e, t, in_addr_a, ei);
        end
        vectors++;
        if (wt_addr_a !== ew) begin
          miscompares++;
          $display("[TB] FAIL wt_addr e=%0d t=%0d: got %0d expected %0d", e, t, wt_addr_a, ew);
        end
        vectors++;
        if ({busy_a, wr_req_a, done_a} !== 3'b100 || got_c !== ec) begin
          miscompares++;
          $display("[TB] FAIL load_status e=%0d t=%0d: got %b/%h expected 100/%h",
                   e, t, {busy_a, wr_req_a, done_a}, got_c, ec);
        end
        if (!stall && ((e == 0 && (t == 3 || t == 33)) || (e == 96 && t == 0))) begin
          vectors++;
          if (in_addr_a !== ((e == 96) ? 18'd12 : (t == 3) ? 18'd3 : 18'd681)) begin
            miscompares++;
            $display("[TB] FAIL spot_in_addr e=%0d t=%0d: got %0d", e, t, in_addr_a);
          end
        end
        if (!stall && e == 1 && t == 0) begin
          vectors++;
          if (wt_addr_a !== 16'd363) begin
            miscompares++;
            $display("[TB] FAIL spot_wt_addr: got %0d expected 363", wt_addr_a);
          end
        end
        if (!stall) t++;
      end
      for (int i = 0; i < LAT_A; i++) begin
        @(negedge clk);
        stall_a = 1'($urandom_range(1));
        ack_a = 1'($urandom_range(1));
        start_a = 1'($urandom_range(1));
        #1;
        got_c = {out_row_a, out_col_a, out_ch_a};
        vectors++;
        if ({rd_en_a, mac_en_a, mac_clr_a, mac_last_a, busy_a, wr_req_a, done_a} !== 7'b0000100
            || got_c !== ec) begin
          miscompares++;
          $display("[TB] FAIL drain e=%0d c=%0d: got %b/%h expected 0000100/%h", e, i,
                   {rd_en_a, mac_en_a, mac_clr_a, mac_last_a, busy_a, wr_req_a, done_a}, got_c, ec);
        end
      end
      d = (e == 0) ? 10 : int'($urandom_range(2));
      for (int i = 0; i <= d; i++) begin
        @(negedge clk);
        ack_a = (i == d);
        stall_a = 1'($urandom_range(1));
        start_a = 1'($urandom_range(1));
        #1;
        got_c = {out_row_a, out_col_a, out_ch_a};
        vectors++;
        if ({rd_en_a, mac_en_a, mac_clr_a, mac_last_a, busy_a, wr_req_a, done_a} !== 7'b0000110
            || got_c !== ec) begin
          miscompares++;
          $display("[TB] FAIL write e=%0d c=%0d: got %b/%h expected 0000110/%h", e, i,
                   {rd_en_a, mac_en_a, mac_clr_a, mac_last_a, busy_a, wr_req_a, done_a}, got_c, ec);
        end
      end
    end
  endtask

  task automatic restart_and_check(input string tag);
    @(negedge clk);
    rst = 0;
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    #1;
    vectors++;
    if ({in_addr_a, wt_addr_a, out_row_a, out_col_a, out_ch_a} !== 53'd0 ||
        {rd_en_a, mac_en_a, mac_clr_a, mac_last_a, busy_a} !== 5'b11101) begin
      miscompares++;
      $display("[TB] FAIL %s_restart: got addr %0d/%0d strobes %b coord %h expected 0/0 11101 0",
               tag, in_addr_a, wt_addr_a, {rd_en_a, mac_en_a, mac_clr_a, mac_last_a, busy_a},
               {out_row_a, out_col_a, out_ch_a});
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [59:0] snap;
    @(negedge clk);
    ack_a = 0; stall_a = 0; start_a = 0;
    repeat (TAPS_A + 1) @(negedge clk);
    #1;
    vectors++;
    if ({busy_a, wr_req_a, done_a, rd_en_a} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL in_drain: got %b expected 1000", {busy_a, wr_req_a, done_a, rd_en_a});
    end
    rst = 1;
    #1;
    snap = {in_addr_a, wt_addr_a, rd_en_a, mac_clr_a, mac_en_a, mac_last_a, wr_req_a,
            out_row_a, out_col_a, out_ch_a, busy_a, done_a};
    vectors++;
    if (snap !== 60'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_drain: got %h expected 0", snap);
    end
    restart_and_check("drain");
  endtask

  task automatic test_reset_mid_write();
    logic [59:0] snap;
    repeat (TAPS_A + LAT_A) @(negedge clk);
    #1;
    vectors++;
    if ({busy_a, wr_req_a, done_a} !== 3'b110 || {out_row_a, out_col_a, out_ch_a} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL in_write: got %b/%h expected 110/0", {busy_a, wr_req_a, done_a},
               {out_row_a, out_col_a, out_ch_a});
    end
    rst = 1;
    #1;
    snap = {in_addr_a, wt_addr_a, rd_en_a, mac_clr_a, mac_en_a, mac_last_a, wr_req_a,
            out_row_a, out_col_a, out_ch_a, busy_a, done_a};
    vectors++;
    if (snap !== 60'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_write: got %h expected 0", snap);
    end
    restart_and_check("write");
  endtask

  task automatic test_small_layer();
    int n, nx, ndone, e, t;
    logic [17:0] ei;
    logic [15:0] ew;
    logic [18:0] ec;
    n = 0; nx = 0; ndone = 0;
    @(negedge clk);
    start_b = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      start_b = 0;
      #1;
      vectors++;
      if (busy_b !== (c <= DONE_AT_B) || rd_en_b !== mac_en_b) begin
        miscompares++;
        $display("[TB] FAIL small_busy c=%0d: got busy %b rd/mac %b%b expected busy %b",
                 c, busy_b, rd_en_b, mac_en_b, (c <= DONE_AT_B));
      end
      if (rd_en_b) begin
        e = n / TAPS_B;
        t = n % TAPS_B;
        ei = 18'(exp_in(IN_W_B, IN_C_B, K_B, S_B, OHW_B, OC_B, e, t));
        ew = 16'(exp_wt(IN_C_B, K_B, OC_B, e, t));
        vectors++;
        if (in_addr_b !== ei || wt_addr_b !== ew ||
            {mac_clr_b, mac_last_b} !== {t == 0, t == TAPS_B - 1}) begin
          miscompares++;
          $display("[TB] FAIL small_tap n=%0d: got %0d/%0d clr/last %b%b expected %0d/%0d %b%b",
                   n, in_addr_b, wt_addr_b, mac_clr_b, mac_last_b, ei, ew, t == 0, t == TAPS_B - 1);
        end
        n++;
      end
      if (wr_req_b) begin
        ec = exp_coord(OHW_B, OC_B, nx);
        vectors++;
        if ({out_row_b, out_col_b, out_ch_b} !== ec) begin
          miscompares++;
          $display("[TB] FAIL small_xfer #%0d: got %h expected %h", nx,
                   {out_row_b, out_col_b, out_ch_b}, ec);
        end
        nx++;
      end
      if (done_b) begin
        ndone++;
        vectors++;
        if (c != DONE_AT_B) begin
          miscompares++;
          $display("[TB] FAIL small_done_time: got cycle %0d expected %0d", c, DONE_AT_B);
        end
      end
    end
    vectors++;
    if (n != N_B * TAPS_B || nx != N_B || ndone != 1) begin
      miscompares++;
      $display("[TB] FAIL small_totals: got taps %0d xfers %0d dones %0d expected %0d %0d 1",
               n, nx, ndone, N_B * TAPS_B, N_B);
    end
  endtask

  initial begin
    rst = 1;
    start_a = 0; stall_a = 0; ack_a = 0;
    start_b = 0; stall_b = 0; ack_b = 1;
    $display("[TB] starting conv1_sched bench");
    test_reset();
    test_layer_walk(98);
    test_reset_mid_drain();
    test_reset_mid_write();
    test_small_layer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
